// File: rtl/hwjsoc_dct_pkg.sv
// Shared constants and FSM state type for the trace-atom DCT packer.
package hwjsoc_dct_pkg;

    localparam int ATOM_W    = 2;
    localparam int MAX_ATOMS = 15;
    localparam int DCT_W     = MAX_ATOMS * ATOM_W;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENDING = 2'd1,
        ENDED  = 2'd2
    } dct_state_t;

endpackage

// File: rtl/hwjsoc_dct_outreg.sv
// Single-entry valid/ready holding register for packed words.
// The contents are only reloaded when the slot is free, so the held word
// stays stable for as long as the consumer stalls.
module hwjsoc_dct_outreg
    import hwjsoc_dct_pkg::*;
#(
    parameter int W = DCT_W + CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data_out,
    output logic         free
);

    assign free = !valid | ready;

    // Load on request (caller only loads when free); otherwise drop valid on take.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            data_out <= data_in;
        end else if (ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/hwjsoc_cpu_c_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom words with flush and end-of-test drain.
//
//   state  | meaning
//   RUN    | accepting atoms, words emitted when full or flushed
//   ENDING | draining: no new atoms, partial word forced out
//   ENDED  | drain complete, terminal until reset
module hwjsoc_cpu_c_dct_packer #(
    parameter int MAX_ATOMS = hwjsoc_dct_pkg::MAX_ATOMS,
    parameter int ATOM_W    = hwjsoc_dct_pkg::ATOM_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                atom_valid,
    input  logic [ATOM_W-1:0]                   atom,
    output logic                                atom_ready,
    input  logic                                flush,
    input  logic                                end_req,
    output logic [MAX_ATOMS*ATOM_W-1:0]         dct_buffer,
    output logic [hwjsoc_dct_pkg::CNT_W-1:0]    dct_count,
    output logic                                dct_valid,
    input  logic                                dct_ready,
    output logic                                test_ending,
    output logic                                test_has_ended
);

    import hwjsoc_dct_pkg::*;

    localparam int DW = MAX_ATOMS * ATOM_W;

    dct_state_t       state, state_nxt;
    logic [DW-1:0]    acc, acc_nxt, base_acc;
    logic [CNT_W-1:0] acc_cnt, cnt_nxt, base_cnt;
    logic             flush_pend, pend_nxt;
    logic             full, flush_eff, transfer, accept, slot_free;

    assign full      = (acc_cnt == CNT_W'(MAX_ATOMS));
    // Draining behaves like a flush that never clears.
    assign flush_eff = flush_pend | (state == ENDING);
    assign transfer  = slot_free & (full | (flush_eff & (acc_cnt != '0)));
    // A full accumulator can still take an atom on the edge it empties.
    assign atom_ready = !reset & (state == RUN) & !flush_pend & (!full | transfer);
    assign accept     = atom_valid & atom_ready;

    hwjsoc_dct_outreg #(.W(DW + CNT_W)) u_outreg (
        .clk      (clk),
        .reset    (reset),
        .load     (transfer),
        .data_in  ({acc_cnt, acc}),
        .ready    (dct_ready),
        .valid    (dct_valid),
        .data_out ({dct_count, dct_buffer}),
        .free     (slot_free)
    );

    // Accumulator next value: clear on transfer, then drop the accepted atom into the next slot.
    always_comb begin
        base_acc = transfer ? '0 : acc;
        base_cnt = transfer ? '0 : acc_cnt;
        acc_nxt  = base_acc;
        cnt_nxt  = base_cnt;
        if (accept) begin
            for (int i = 0; i < MAX_ATOMS; i++) begin
                if (base_cnt == CNT_W'(i)) acc_nxt[i*ATOM_W +: ATOM_W] = atom;
            end
            cnt_nxt = base_cnt + CNT_W'(1);
        end
        // A flush with nothing to emit is dropped straight away.
        pend_nxt = (flush | (flush_pend & !transfer)) & (cnt_nxt != '0);
    end

    // Accumulator and pending-flush registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            acc_cnt    <= cnt_nxt;
            flush_pend <= pend_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_nxt      = state;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        case (state)
            RUN: begin
                if (end_req) state_nxt = ENDING;
            end
            ENDING: begin
                test_ending = 1'b1;
                if ((acc_cnt == '0) && !dct_valid) state_nxt = ENDED;
            end
            ENDED: begin
                test_has_ended = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_hwjsoc_cpu_c_dct_packer.sv
// Directed self-checking bench for the DCT packer.
module tb_hwjsoc_cpu_c_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        test_ending;
    logic        test_has_ended;

    int errors = 0;
    int checks = 0;

    logic [33:0] words[$];
    logic        stall_seen;
    logic [1:0]  seq[64];

    hwjsoc_cpu_c_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    // Record every taken word and any stall seen while an atom was offered.
    always @(posedge clk) begin
        if (!reset) begin
            if (dct_valid && dct_ready) words.push_back({dct_count, dct_buffer});
            if (atom_valid && !atom_ready) stall_seen = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input int start, input int n, input int budget,
                         output int got, output int used);
        logic will;
        got  = 0;
        used = 0;
        while (got < n && used < budget) begin
            atom_valid = 1'b1;
            atom       = seq[start + got];
            #1;
            will = atom_ready;
            @(negedge clk);
            if (will) got++;
            used++;
        end
        atom_valid = 1'b0;
        atom       = 2'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; atom_valid = 1'b0; atom = 2'd0; flush = 1'b0;
        end_req = 1'b0; dct_ready = 1'b1;
        cycles(3);
        atom_valid = 1'b1;
        #1;
        checks++; if (atom_ready !== 1'b0) begin errors++; $display("FAIL reset_atom_ready: got %b want 0", atom_ready); end
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL reset_dct_valid: got %b want 0", dct_valid); end
        checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL reset_dct_count: got %0d want 0", dct_count); end
        checks++; if (dct_buffer !== 30'd0) begin errors++; $display("FAIL reset_dct_buffer: got %h want 0", dct_buffer); end
        checks++; if ({test_ending, test_has_ended} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", {test_ending, test_has_ended}); end
        atom_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (atom_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", atom_ready); end
    endtask

    task automatic test_full_word();
        int got, used;
        dct_ready = 1'b1;
        words.delete();
        for (int i = 0; i < 64; i++) seq[i] = 2'(i % 4);
        offer(0, 15, 20, got, used);
        checks++; if (got !== 15 || used !== 15) begin errors++; $display("FAIL full_accepts: got %0d in %0d cycles want 15 in 15", got, used); end
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL full_latency_early: dct_valid %b want 0", dct_valid); end
        @(negedge clk);
        checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL full_latency: dct_valid %b want 1", dct_valid); end
        checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL full_count: got %0d want 15", dct_count); end
        checks++; if (dct_buffer !== 30'h24E4E4E4) begin errors++; $display("FAIL full_buffer: got %h want 24e4e4e4", dct_buffer); end
        cycles(3);
        checks++; if (words.size() !== 1) begin errors++; $display("FAIL full_word_count: got %0d want 1", words.size()); end
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop: got %b want 0", dct_valid); end
    endtask

    task automatic test_all_threes();
        int got, used;
        dct_ready  = 1'b1;
        words.delete();
        stall_seen = 1'b0;
        for (int i = 0; i < 64; i++) seq[i] = 2'd3;
        offer(0, 30, 30, got, used);
        checks++; if (got !== 30) begin errors++; $display("FAIL threes_accepts: got %0d want 30", got); end
        checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL threes_stall: atom_ready went low"); end
        cycles(4);
        checks++; if (words.size() !== 2) begin errors++; $display("FAIL threes_words: got %0d want 2", words.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ((words.size() > k ? words[k] : 34'bx) !== {4'd15, 30'h3FFFFFFF}) begin
                errors++; $display("FAIL threes_word%0d: got %h want %h", k, (words.size() > k ? words[k] : 34'bx), {4'd15, 30'h3FFFFFFF});
            end
        end
    endtask

    task automatic test_flush();
        int got, used;
        dct_ready = 1'b1;
        words.delete();
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3;
        offer(0, 3, 6, got, used);
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL flush_no_early_word: dct_valid %b want 0", dct_valid); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cycles(4);
        checks++; if (words.size() !== 1) begin errors++; $display("FAIL flush_words: got %0d want 1", words.size()); end
        checks++;
        if ((words.size() > 0 ? words[0] : 34'bx) !== {4'd3, 30'h39}) begin
            errors++; $display("FAIL flush_word: got %h want %h", (words.size() > 0 ? words[0] : 34'bx), {4'd3, 30'h39});
        end
        words.delete();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (atom_ready !== 1'b1) begin errors++; $display("FAIL empty_flush_ready: got %b want 1", atom_ready); end
        cycles(5);
        checks++; if (words.size() !== 0) begin errors++; $display("FAIL empty_flush_words: got %0d want 0", words.size()); end
    endtask

    task automatic test_backpressure();
        int got, used, cyc;
        logic [33:0] exp[3];
        exp[0] = {4'd15, 30'h24E4E4E4};
        exp[1] = {4'd15, 30'h13939393};
        exp[2] = {4'd10, 30'h000E4E4E};
        dct_ready = 1'b0;
        words.delete();
        for (int i = 0; i < 64; i++) seq[i] = 2'(i % 4);
        offer(0, 40, 35, got, used);
        checks++; if (got !== 30) begin errors++; $display("FAIL bp_accepts: got %0d want 30", got); end
        atom_valid = 1'b1;
        #1;
        checks++; if (atom_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", atom_ready); end
        atom_valid = 1'b0;
        checks++; if ({dct_valid, dct_count, dct_buffer} !== {1'b1, exp[0]}) begin errors++; $display("FAIL bp_held: got %b/%h want 1/%h", dct_valid, {dct_count, dct_buffer}, exp[0]); end
        cycles(5);
        checks++; if ({dct_valid, dct_count, dct_buffer} !== {1'b1, exp[0]}) begin errors++; $display("FAIL bp_stable: got %b/%h want 1/%h", dct_valid, {dct_count, dct_buffer}, exp[0]); end
        dct_ready = 1'b1;
        offer(30, 10, 20, got, used);
        checks++; if (got !== 10) begin errors++; $display("FAIL bp_resume_accepts: got %0d want 10", got); end
        end_req = 1'b1;
        @(negedge clk);
        end_req = 1'b0;
        cyc = 0;
        while (!test_has_ended && cyc < 50) begin @(negedge clk); cyc++; end
        checks++; if (test_has_ended !== 1'b1) begin errors++; $display("FAIL bp_drain_done: got %b want 1", test_has_ended); end
        checks++; if (words.size() !== 3) begin errors++; $display("FAIL bp_words: got %0d want 3", words.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ((words.size() > k ? words[k] : 34'bx) !== exp[k]) begin
                errors++; $display("FAIL bp_word%0d: got %h want %h", k, (words.size() > k ? words[k] : 34'bx), exp[k]);
            end
        end
    endtask

    task automatic test_end_drain();
        int got, used, cyc;
        do_reset();
        dct_ready = 1'b1;
        words.delete();
        for (int i = 0; i < 64; i++) seq[i] = 2'(i % 4);
        offer(0, 5, 8, got, used);
        end_req = 1'b1;
        @(negedge clk);
        end_req = 1'b0;
        checks++; if (test_ending !== 1'b1) begin errors++; $display("FAIL end_ending: got %b want 1", test_ending); end
        atom_valid = 1'b1;
        #1;
        checks++; if (atom_ready !== 1'b0) begin errors++; $display("FAIL end_ready_low: got %b want 0", atom_ready); end
        cyc = 0;
        while (!test_has_ended && cyc < 30) begin @(negedge clk); cyc++; end
        checks++; if ({test_ending, test_has_ended} !== 2'b01) begin errors++; $display("FAIL end_ended: got %b want 01", {test_ending, test_has_ended}); end
        checks++;
        if (words.size() !== 1 || (words.size() > 0 ? words[0] : 34'bx) !== {4'd5, 30'hE4}) begin
            errors++; $display("FAIL end_word: got n=%0d %h want n=1 %h", words.size(), (words.size() > 0 ? words[0] : 34'bx), {4'd5, 30'hE4});
        end
        end_req = 1'b1;
        @(negedge clk);
        end_req = 1'b0;
        cycles(3);
        #1;
        checks++; if ({test_has_ended, atom_ready} !== 2'b10) begin errors++; $display("FAIL end_sticky: got %b want 10", {test_has_ended, atom_ready}); end
        checks++; if (words.size() !== 1) begin errors++; $display("FAIL end_no_extra: got %0d want 1", words.size()); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({atom_ready, dct_valid, dct_count, dct_buffer, test_ending, test_has_ended} !== 38'd0) begin
            errors++; $display("FAIL end_reset_outputs: got %b/%b/%0d/%h/%b/%b want all 0", atom_ready, dct_valid, dct_count, dct_buffer, test_ending, test_has_ended);
        end
        atom_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if ({atom_ready, test_has_ended} !== 2'b10) begin errors++; $display("FAIL end_after_reset: got %b want 10", {atom_ready, test_has_ended}); end
    endtask

    task automatic test_reset_midop();
        int got, used;
        dct_ready = 1'b0;
        words.delete();
        for (int i = 0; i < 64; i++) seq[i] = 2'd2;
        offer(0, 17, 20, got, used);
        checks++; if ({dct_valid, got} !== {1'b1, 32'd17}) begin errors++; $display("FAIL midop_setup: valid %b accepts %0d want 1/17", dct_valid, got); end
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        dct_ready = 1'b1;
        cycles(10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cycles(6);
        checks++; if (words.size() !== 0) begin errors++; $display("FAIL midop_discard: got %0d words want 0", words.size()); end
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL midop_valid: got %b want 0", dct_valid); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_all_threes();
        test_flush();
        test_backpressure();
        test_end_drain();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
